golden_nonce_reporter: RTL and testbench

GOLDEN_NONCE_REPORTER -- requirements
Module: golden_nonce_reporter

---
 rtl/nonce_report_pkg.sv | 10 +
 rtl/nonce_fifo.sv | 51 +++++
 rtl/golden_nonce_reporter.sv | 80 ++++++++
 tb/tb_golden_nonce_reporter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/nonce_report_pkg.sv
// nonce_report_pkg: shared FSM states, frame constants and checksum helper for the golden nonce reporter
package nonce_report_pkg;
    // Frame states in transmit order; IDLE separates consecutive frames.
    typedef enum logic [2:0] {IDLE, SYNC, B3, B2, B1, B0, CSUM} state_t;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN         = 6;
    function automatic logic [7:0] nonce_csum(input logic [31:0] n);
        return n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
    endfunction
endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo: DEPTH-entry 32-bit FIFO with show-ahead head, level count and full/empty flags
//   hash_clk, rst_n    : clock, asynchronous active-low reset
//   push, wdata        : write request and data (accepted when not full, or full with a same-edge pop)
//   pop, rdata         : read request and current head entry
//   full, empty, level : occupancy status
module nonce_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       hash_clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [31:0]                wdata,
    input  logic                       pop,
    output logic [31:0]                rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;
    assign full  = level_q == LW'(DEPTH);
    assign empty = level_q == '0;
    assign level = level_q;
    assign rdata = mem_q[rd_q];
    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    always_comb begin
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end
    always_ff @(posedge hash_clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/golden_nonce_reporter.sv
// golden_nonce_reporter: queues winning nonces and streams each as a 6-byte frame (sync, 4 nonce bytes, XOR checksum)
//   hash_clk, rst_n            : clock, asynchronous active-low reset
//   golden_valid, golden_nonce : one-cycle strobe and winning nonce from the miner
//   tx_data, tx_valid, tx_ready: registered byte stream with valid/ready handshake
//   fifo_level                 : stored nonces; drop_count: saturating overflow count; busy: work pending
module golden_nonce_reporter
    import nonce_report_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                   hash_clk,
    input  logic                   rst_n,
    input  logic                   golden_valid,
    input  logic [31:0]            golden_nonce,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             drop_count,
    output logic                   busy
);
    state_t      state_q, state_d;
    logic [31:0] frame_q, frame_d, head;
    logic [7:0]  tx_data_q, tx_data_d, drop_q, drop_d;
    logic        tx_valid_q, tx_valid_d;
    logic        full, empty, pop, xfer;
    nonce_fifo #(.DEPTH(DEPTH)) u_fifo (
        .hash_clk (hash_clk),
        .rst_n    (rst_n),
        .push     (golden_valid),
        .wdata    (golden_nonce),
        .pop      (pop),
        .rdata    (head),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );
    assign pop        = state_q == IDLE && !empty;
    assign xfer       = tx_valid_q && tx_ready;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign drop_count = drop_q;
    assign busy       = state_q != IDLE || !empty;
    always_comb begin
        frame_d = pop ? head : frame_q;
        drop_d  = (golden_valid && full && !pop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        state_d = state_q;
        if (state_q == IDLE)
            state_d = pop ? SYNC : IDLE;
        else if (xfer)
            state_d = state_q == CSUM ? IDLE : state_t'(state_q + 3'd1);
        // Outputs are computed from the next state so they can be registered.
        tx_valid_d = state_d != IDLE;
        case (state_d)
            SYNC:    tx_data_d = SYNC_BYTE;
            B3:      tx_data_d = frame_d[31:24];
            B2:      tx_data_d = frame_d[23:16];
            B1:      tx_data_d = frame_d[15:8];
            B0:      tx_data_d = frame_d[7:0];
            CSUM:    tx_data_d = nonce_csum(frame_d);
            default: tx_data_d = 8'h00;
        endcase
    end
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            drop_q     <= drop_d;
        end
    end
endmodule

// File: tb/tb_golden_nonce_reporter.sv
// tb_golden_nonce_reporter: directed and random stimulus checked against a queue-based reference model
module tb_golden_nonce_reporter;
    import nonce_report_pkg::*;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    logic          hash_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          golden_valid = 1'b0;
    logic [31:0]   golden_nonce = '0;
    logic          tx_ready = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic [LW-1:0] fifo_level;
    logic [7:0]    drop_count;
    logic          busy;
    int            checks = 0;
    int            errors = 0;
    golden_nonce_reporter #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .hash_clk     (hash_clk),
        .rst_n        (rst_n),
        .golden_valid (golden_valid),
        .golden_nonce (golden_nonce),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .busy         (busy)
    );
    always #5 hash_clk = ~hash_clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [7:0] xsum(input logic [31:0] n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 4; i++) s = s ^ n[8*i +: 8];
        return s;
    endfunction
    // Reference model: stored nonces, remaining bytes of the frame on the wire, drop counter.
    logic [31:0] m_fifo [$];
    logic [7:0]  m_bytes [$];
    int          m_drop = 0;
    always @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_bytes.delete();
            m_drop = 0;
        end else begin
            automatic bit was_full = m_fifo.size() == DEPTH;
            automatic bit take = m_bytes.size() == 0 && m_fifo.size() != 0;
            if (m_bytes.size() != 0 && tx_ready) void'(m_bytes.pop_front());
            if (take) begin
                automatic logic [31:0] n = m_fifo.pop_front();
                m_bytes = '{8'hA5, n[31:24], n[23:16], n[15:8], n[7:0], xsum(n)};
            end
            if (golden_valid) begin
                if (!was_full || take) m_fifo.push_back(golden_nonce);
                else if (m_drop < 255) m_drop++;
            end
        end
    end
    logic [7:0] log_q [$];
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;
    always @(negedge hash_clk) begin
        if (!rst_n) prev_v = 1'b0;
        else begin
            check("valid", tx_valid, m_bytes.size() != 0);
            if (m_bytes.size() != 0) check("data", tx_data, m_bytes[0]);
            check("level", fifo_level, m_fifo.size());
            check("drops", drop_count, m_drop);
            check("busy", busy, m_bytes.size() != 0 || m_fifo.size() != 0);
            if (prev_v && !prev_r && tx_valid) check("hold", tx_data, prev_d);
            if (tx_valid && tx_ready) log_q.push_back(tx_data);
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_d = tx_data;
        end
    end
    task automatic tick(input int n = 1);
        repeat (n) @(posedge hash_clk);
        #1;
    endtask
    task automatic strobe(input logic [31:0] n);
        golden_valid = 1'b1;
        golden_nonce = n;
        tick();
        golden_valid = 1'b0;
    endtask
    initial begin
        int base;
        logic [7:0] exp1 [6];
        logic [7:0] exp2 [6];
        exp1 = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        exp2 = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, xsum(32'hDEADBEEF)};
        tick();
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_count, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(2);
        // single frame at full rate, 2-cycle latency
        tx_ready = 1'b1;
        base = log_q.size();
        strobe(32'h12345678);
        @(negedge hash_clk);
        check("lat1_valid", tx_valid, 0);
        @(negedge hash_clk);
        check("lat2_valid", tx_valid, 1);
        check("lat2_data", tx_data, 8'hA5);
        tick(9);
        check("s1_len", log_q.size() - base, FRAME_LEN);
        for (int i = 0; i < 6; i++) check($sformatf("s1_b%0d", i), log_q[base+i], exp1[i]);
        // ready toggling
        tx_ready = 1'b0;
        base = log_q.size();
        strobe(32'hDEADBEEF);
        for (int i = 0; i < 20; i++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        tx_ready = 1'b1;
        tick(3);
        check("s2_len", log_q.size() - base, FRAME_LEN);
        for (int i = 0; i < 6; i++) check($sformatf("s2_b%0d", i), log_q[base+i], exp2[i]);
        // overflow with consumer stalled
        tx_ready = 1'b0;
        base = log_q.size();
        for (int n = 1; n <= 6; n++) strobe(n);
        check("s3_level", fifo_level, 4);
        check("s3_drop", drop_count, 1);
        tx_ready = 1'b1;
        tick(40);
        check("s3_len", log_q.size() - base, 30);
        for (int f = 0; f < 5; f++) begin
            check($sformatf("s3_sync%0d", f), log_q[base+6*f], 8'hA5);
            check($sformatf("s3_nonce%0d", f), log_q[base+6*f+4], f + 1);
        end
        // push into a full FIFO on the same edge as a pop
        tx_ready = 1'b0;
        base = log_q.size();
        for (int n = 0; n < 5; n++) strobe(32'hA0000000 + n);
        tx_ready = 1'b1;
        tick(6);
        strobe(32'hA00000FF);
        check("s4_level", fifo_level, 4);
        check("s4_drop", drop_count, 1);
        tick(45);
        check("s4_len", log_q.size() - base, 36);
        check("s4_last", log_q[base+34], 8'hFF);
        // reset mid-frame in B2
        tx_ready = 1'b0;
        strobe(32'h11223344);
        strobe(32'h55667788);
        tx_ready = 1'b1;
        tick(2);
        tx_ready = 1'b0;
        check("s5_b2", tx_data, 8'h22);
        #2 rst_n = 1'b0;
        #1;
        check("s5_valid", tx_valid, 0);
        check("s5_level", fifo_level, 0);
        check("s5_busy", busy, 0);
        check("s5_data", tx_data, 0);
        golden_valid = 1'b1;
        tick();
        golden_valid = 1'b0;
        check("s5_ignore", fifo_level, 0);
        rst_n = 1'b1;
        tick();
        base = log_q.size();
        tx_ready = 1'b1;
        strobe(32'hCAFEF00D);
        tick(10);
        check("s5_len", log_q.size() - base, FRAME_LEN);
        check("s5_first", log_q[base], 8'hA5);
        check("s5_csum", log_q[base+5], xsum(32'hCAFEF00D));
        // random traffic
        for (int i = 0; i < 400; i++) begin
            golden_valid = $urandom_range(0, 3) == 0;
            golden_nonce = $urandom;
            tx_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        golden_valid = 1'b0;
        // drop counter saturation
        tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) strobe($urandom);
        check("s7_sat", drop_count, 8'hFF);
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
